// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: merges the CPU ibus and dbus onto one registered
// memory bus, round-robin, one transaction at a time, with a watchdog.
//
// Ports:
//   i_clock, i_reset_n          clock, async active-low reset
//   i_ibus_* / o_ibus_*         fetch master (read only)
//   i_dbus_* / o_dbus_*         data master (read/write, byte mask)
//   o_bus_* / i_bus_*           shared downstream bus, all outputs registered
//   o_timeout                   sticky watchdog fault
//   o_grant_dbus                current/last grant went to dbus
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_ibus_request,
  output logic        o_ibus_ready,
  input  logic [31:0] i_ibus_address,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_rw,
  input  logic        i_dbus_request,
  output logic        o_dbus_ready,
  input  logic [31:0] i_dbus_address,
  output logic [31:0] o_dbus_rdata,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wmask,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask,
  output logic        o_timeout,
  output logic        o_grant_dbus
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value on the last wait cycle before the fault fires.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESPOND
  } state_t;

  state_t        state, state_d;
  logic          last_dbus, last_dbus_d;
  logic [CW-1:0] count, count_d;

  logic          bus_request_d;
  logic          bus_rw_d;
  logic [31:0]   bus_address_d;
  logic [31:0]   bus_wdata_d;
  logic [3:0]    bus_wmask_d;
  logic          ibus_ready_d;
  logic          dbus_ready_d;
  logic [31:0]   ibus_rdata_d;
  logic [31:0]   dbus_rdata_d;
  logic          timeout_d;
  logic          grant_dbus_d;

  logic          pick_dbus;
  logic          finish;
  logic [31:0]   ret_data;

  always_comb begin
    state_d       = state;
    last_dbus_d   = last_dbus;
    count_d       = count;
    bus_request_d = o_bus_request;
    bus_rw_d      = o_bus_rw;
    bus_address_d = o_bus_address;
    bus_wdata_d   = o_bus_wdata;
    bus_wmask_d   = o_bus_wmask;
    ibus_ready_d  = 1'b0;
    dbus_ready_d  = 1'b0;
    ibus_rdata_d  = o_ibus_rdata;
    dbus_rdata_d  = o_dbus_rdata;
    timeout_d     = o_timeout;
    grant_dbus_d  = o_grant_dbus;
    pick_dbus     = 1'b0;
    finish        = 1'b0;
    ret_data      = i_bus_rdata;

    unique case (state)
      IDLE: begin
        if (i_ibus_request || i_dbus_request) begin
          // On a tie, whoever did not win last time goes first.
          pick_dbus = i_dbus_request &&
                      (!i_ibus_request || !last_dbus);
          last_dbus_d   = pick_dbus;
          grant_dbus_d  = pick_dbus;
          count_d       = '0;
          bus_request_d = 1'b1;
          state_d       = BUS;
          if (pick_dbus) begin
            bus_address_d = i_dbus_address;
            bus_rw_d      = i_dbus_rw;
            bus_wdata_d   = i_dbus_wdata;
            bus_wmask_d   = i_dbus_wmask;
          end else begin
            bus_address_d = i_ibus_address;
            bus_rw_d      = 1'b0;
            bus_wdata_d   = '0;
            bus_wmask_d   = '0;
          end
        end
      end

      BUS: begin
        // Slave ready beats the watchdog on the same cycle.
        if (i_bus_ready) begin
          finish = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (count == CNT_LAST) begin
            finish    = 1'b1;
            ret_data  = TIMEOUT_RDATA;
            timeout_d = 1'b1;
          end else begin
            count_d = count + 1'b1;
          end
        end
        if (finish) begin
          bus_request_d = 1'b0;
          state_d       = RESPOND;
          if (o_grant_dbus) begin
            dbus_ready_d = 1'b1;
            // Writes leave the last read value in place.
            if (!o_bus_rw) dbus_rdata_d = ret_data;
          end else begin
            ibus_ready_d = 1'b1;
            ibus_rdata_d = ret_data;
          end
        end
      end

      RESPOND: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      last_dbus     <= 1'b1;
      count         <= '0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_bus_wmask   <= '0;
      o_ibus_ready  <= 1'b0;
      o_dbus_ready  <= 1'b0;
      o_ibus_rdata  <= '0;
      o_dbus_rdata  <= '0;
      o_timeout     <= 1'b0;
      o_grant_dbus  <= 1'b0;
    end else begin
      state         <= state_d;
      last_dbus     <= last_dbus_d;
      count         <= count_d;
      o_bus_request <= bus_request_d;
      o_bus_rw      <= bus_rw_d;
      o_bus_address <= bus_address_d;
      o_bus_wdata   <= bus_wdata_d;
      o_bus_wmask   <= bus_wmask_d;
      o_ibus_ready  <= ibus_ready_d;
      o_dbus_ready  <= dbus_ready_d;
      o_ibus_rdata  <= ibus_rdata_d;
      o_dbus_rdata  <= dbus_rdata_d;
      o_timeout     <= timeout_d;
      o_grant_dbus  <= grant_dbus_d;
    end
  end

endmodule
